detector_arbiter: RTL and testbench

- Shares one serial pattern-detector FSM (1-bit `x` in, 2-bit `output_code` out) between two word-level requesters.
- Accepts a WIDTH-bit word from the granted requester and holds the detector cleared between jobs.
- Streams the word into the detector one bit per clock, counting detector hits on each code bit.
- Returns the per-word hit counts tagged with the requester ID; arbitration is round-robin.

---
 rtl/detector_arbiter_pkg.sv | 18 +
 rtl/detector_arbiter_rr_arb2.sv | 15 +
 rtl/detector_arbiter.sv | 126 ++++++++++++
 tb/tb_detector_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/detector_arbiter_pkg.sv
// Shared types and helpers for the detector_arbiter block.
package detector_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam int REQ_N = 2;

  // Counters narrower than 32 bits are widened by the caller; max_val is the saturation ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/detector_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module rr_arb2
  import detector_arbiter_pkg::*;
(
  input  logic [REQ_N-1:0] valid_i,
  input  logic             last_grant_i,
  output logic [REQ_N-1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (&valid_i) grant_o = last_grant_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/detector_arbiter.sv
// Time-shares one serial pattern detector between two word requesters, returning per-word hit counts.
// Optional macro DETECTOR_ARBITER_LSB_FIRST_EN streams words LSB first instead of MSB first.
module detector_arbiter
  import detector_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             det_clr,
  output logic             det_x,
  input  logic [1:0]       det_code,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_cnt0,
  output logic [CNT_W-1:0] res_cnt1,
  input  logic             res_ready
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       grant;
  logic             shift_bit;
  logic [WIDTH-1:0] shreg_nxt;

  rr_arb2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

`ifdef DETECTOR_ARBITER_LSB_FIRST_EN
  assign shift_bit = shreg_q[0];
  assign shreg_nxt = {1'b0, shreg_q[WIDTH-1:1]};
`else
  assign shift_bit = shreg_q[WIDTH-1];
  assign shreg_nxt = {shreg_q[WIDTH-2:0], 1'b0};
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    shreg_d      = shreg_q;
    id_d         = id_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    idx_d        = idx_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    det_clr      = 1'b1;
    det_x        = 1'b0;
    res_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          req0_ready   = grant[0];
          req1_ready   = grant[1];
          shreg_d      = grant[1] ? req1_data : req0_data;
          id_d         = grant[1];
          last_grant_d = grant[1];
          cnt0_d       = '0;
          cnt1_d       = '0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        idx_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Detector runs only here; det_code reflects the bit being driven this cycle.
        det_clr = 1'b0;
        det_x   = shift_bit;
        shreg_d = shreg_nxt;
        if (det_code[0]) cnt0_d = CNT_W'(sat_inc(32'(cnt0_q), 32'(CNT_MAX)));
        if (det_code[1]) cnt1_d = CNT_W'(sat_inc(32'(cnt1_q), 32'(CNT_MAX)));
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      shreg_q      <= '0;
      id_q         <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      shreg_q      <= shreg_d;
      id_q         <= id_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      idx_q        <= idx_d;
    end
  end

  assign res_id   = id_q;
  assign res_cnt0 = cnt0_q;
  assign res_cnt1 = cnt1_q;

endmodule

// File: tb/tb_detector_arbiter.sv
// Directed, table-driven bench for detector_arbiter with stub and real detector models.
module tb_detector_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       det_clr, det_x;
  logic [1:0] det_code;
  logic       res_valid, res_id;
  logic [3:0] res_cnt0, res_cnt1;
  logic       res_ready;

  logic       s_req0_ready, s_req1_ready, s_det_clr, s_det_x;
  logic [1:0] s_det_code;
  logic       s_res_valid, s_res_id;
  logic [1:0] s_res_cnt0, s_res_cnt1;

  logic       det_mode;
  logic [1:0] dstate;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  detector_arbiter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_clr(det_clr), .det_x(det_x), .det_code(det_code),
    .res_valid(res_valid), .res_id(res_id), .res_cnt0(res_cnt0), .res_cnt1(res_cnt1),
    .res_ready(res_ready)
  );

  // Narrow-counter instance with a detector stub that hits both codes every SHIFT cycle.
  detector_arbiter #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .det_clr(s_det_clr), .det_x(s_det_x), .det_code(s_det_code),
    .res_valid(s_res_valid), .res_id(s_res_id), .res_cnt0(s_res_cnt0), .res_cnt1(s_res_cnt1),
    .res_ready(res_ready)
  );

  assign s_det_code = s_det_clr ? 2'b00 : 2'b11;

  // Real detector: code[0] on "11", code[1] on "101" (overlapping, Mealy on current x).
  always_ff @(posedge clk) begin
    if (det_clr) dstate <= 2'b00;
    else         dstate <= {dstate[0], det_x};
  end

  always_comb begin
    det_code = {1'b0, det_x};
    if (det_mode) det_code = {dstate[1] & ~dstate[0] & det_x, dstate[0] & det_x};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_word(input logic [7:0] s);
    logic [7:0] r;
`ifdef DETECTOR_ARBITER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = s[7-i];
`else
    r = s;
`endif
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_req(input logic id, input logic [7:0] word, output logic ok);
    int n;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_data = word; end
    else    begin req0_valid = 1'b1; req0_data = word; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 30) begin
      @(negedge clk); #1; n++;
    end
    ok = (n < 30);
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b0; req1_data = 8'h3C; end
    else    begin req0_valid = 1'b0; req0_data = 8'h3C; end
  endtask

  task automatic wait_result(output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
  endtask

  task automatic apply_job(input string name, input logic id, input logic [7:0] stream,
                           input logic mode, input logic [3:0] e0, input logic [3:0] e1);
    logic ok, seen;
    logic [7:0] bits;
    int lat;
    det_mode = mode;
    start_req(id, to_word(stream), ok);
    if (ok) begin
      bits = 8'h00; lat = 0; seen = 1'b0;
      for (int n = 1; n <= 30 && !seen; n++) begin
        @(negedge clk);
        if (res_valid) begin seen = 1'b1; lat = n - 1; end
        else if (!det_clr) bits = {bits[6:0], det_x};
      end
      check({name, "_seen"}, 32'(seen), 32'd1);
      check({name, "_lat"}, 32'(lat), 32'd9);
      check({name, "_bits"}, 32'(bits), 32'(stream));
      check({name, "_id"}, 32'(res_id), 32'(id));
      check({name, "_cnt0"}, 32'(res_cnt0), 32'(e0));
      check({name, "_cnt1"}, 32'(res_cnt1), 32'(e1));
      check({name, "_sat"}, 32'({s_res_valid, s_res_cnt0, s_res_cnt1}), 32'h1F);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({name, "_drop"}, 32'(res_valid), 32'd0);
    end
  endtask

  typedef struct {
    logic       id;
    logic [7:0] stream;
    logic       mode;
    logic [3:0] e0;
    logic [3:0] e1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic ok, seen, stable, noready, idle_ok;
    logic [3:0] c0, c1;
    int gcnt;
    logic g[4];
    int gt[4];

    vecs[0] = '{1'b0, 8'b1011_0000, 1'b0, 4'd3, 4'd0};
    vecs[1] = '{1'b1, 8'b1111_1111, 1'b0, 4'd8, 4'd0};
    vecs[2] = '{1'b0, 8'b1011_0000, 1'b1, 4'd1, 4'd1};
    vecs[3] = '{1'b1, 8'b1101_0110, 1'b1, 4'd2, 4'd2};
    vecs[4] = '{1'b0, 8'b1010_1010, 1'b1, 4'd0, 4'd3};
    vecs[5] = '{1'b1, 8'b0000_0001, 1'b1, 4'd0, 4'd0};
    vecs[6] = '{1'b0, 8'b1111_1111, 1'b1, 4'd7, 4'd0};

    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00; res_ready = 1'b0; det_mode = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    idle_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid || req0_ready || req1_ready || !det_clr || det_x) idle_ok = 1'b0;
    end
    check("reset_idle", 32'(idle_ok), 32'd1);
    check("reset_regs", 32'({res_id, res_cnt0, res_cnt1}), 32'd0);
    check("reset_sat", 32'({s_res_valid, s_req0_ready, s_req1_ready, s_det_clr, s_det_x}), 32'b00010);

    for (int i = 0; i < 7; i++)
      apply_job($sformatf("v%0d", i), vecs[i].id, vecs[i].stream, vecs[i].mode, vecs[i].e0, vecs[i].e1);

    // Contention with res_ready held high: grants alternate at the full word rate.
    do_reset();
    det_mode = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hF0; req1_valid = 1'b1; req1_data = 8'h0F;
    gcnt = 0;
    for (int t = 0; t < 80 && gcnt < 4; t++) begin
      #1;
      if (req0_ready || req1_ready) begin
        g[gcnt] = req1_ready; gt[gcnt] = t; gcnt++;
      end
      if (gcnt < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_count", 32'(gcnt), 32'd4);
    if (gcnt == 4) begin
      check("rr_order", 32'({g[0], g[1], g[2], g[3]}), 32'b0101);
      check("rr_gap1", 32'(gt[1] - gt[0]), 32'd11);
      check("rr_gap3", 32'(gt[3] - gt[2]), 32'd11);
    end
    repeat (14) @(negedge clk);
    res_ready = 1'b0;
    check("rr_drained", 32'(res_valid), 32'd0);

    // Result held in DONE while requester 1 waits.
    do_reset();
    det_mode = 1'b1;
    req0_valid = 1'b1; req0_data = to_word(8'hB0);
    req1_valid = 1'b1; req1_data = to_word(8'hD6);
    #1;
    check("hold_grant", 32'({req0_ready, req1_ready}), 32'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_result(seen);
    check("hold_seen", 32'(seen), 32'd1);
    check("hold_res", 32'({res_id, res_cnt0, res_cnt1}), 32'h011);
    c0 = res_cnt0; c1 = res_cnt1;
    stable = 1'b1; noready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!res_valid || res_cnt0 !== c0 || res_cnt1 !== c1) stable = 1'b0;
      if (req1_ready || req0_ready) noready = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    check("hold_noready", 32'(noready), 32'd1);
    res_ready = 1'b1; #1;
    check("hold_no_same_cycle_grant", 32'(req1_ready), 32'd0);
    @(negedge clk);
    res_ready = 1'b0; #1;
    check("hold_next_grant", 32'({res_valid, req1_ready}), 32'b01);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_result(seen);
    check("hold_r1", 32'({seen, res_id, res_cnt0, res_cnt1}), 32'h322);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Reset on the 4th SHIFT cycle aborts the job.
    start_req(1'b0, to_word(8'hB0), ok);
    for (int n = 1; n <= 5; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_idle", 32'({det_clr, det_x, res_valid, req0_ready, req1_ready}), 32'b10000);
    idle_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid || !det_clr) idle_ok = 1'b0;
    end
    check("abort_no_result", 32'(idle_ok), 32'd1);
    apply_job("after_abort", 1'b0, 8'b1101_0110, 1'b1, 4'd2, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
